// File: rtl/irq_enc_pkg.sv
// Shared types and helpers for the irq_encoder_148 priority encoder.
package irq_enc_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  // Highest set index wins; returns 0 for an all-zero vector.
  function automatic logic [CODE_W-1:0] highest_idx(input logic [N_REQ-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_encoder_148_req_sync.sv
// Two-flop synchroniser with a trailing previous-value flop; all flops reset to 1 (idle level).
module req_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] s2,
  output logic [WIDTH-1:0] s2_prev
);

  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= '1;
      s2      <= '1;
      s2_prev <= '1;
    end else begin
      s1      <= d;
      s2      <= s1;
      s2_prev <= s2;
    end
  end

endmodule

// File: rtl/irq_encoder_148.sv
// Clocked 8-to-3 priority encoder with request capture and valid/ack handshake.
// Define IRQ_EDGE_CAPTURE_EN for falling-edge capture; otherwise pending follows the request level.
module irq_encoder_148
  import irq_enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_n,
  input  logic              ei_n,
  input  logic              ack,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              gs_n,
  output logic              eo_n
);

  logic [N_REQ-1:0] s2;
  logic [N_REQ-1:0] s2_prev;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] pending_nxt;
  logic             any_pend;
  state_t           state;

  req_sync #(
    .WIDTH (N_REQ)
  ) u_req_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d       (req_n),
    .s2      (s2),
    .s2_prev (s2_prev)
  );

`ifdef IRQ_EDGE_CAPTURE_EN
  logic [N_REQ-1:0] capture;
  logic [N_REQ-1:0] clear;

  // A capture landing on the same edge as its clear must survive, so OR it in last.
  always_comb begin
    capture     = ~s2 & s2_prev;
    clear       = (state == PRESENT && ack) ? (N_REQ'(1) << code) : '0;
    pending_nxt = (pending & ~clear) | capture;
  end
`else
  logic unused_s2_prev;
  assign unused_s2_prev = ^s2_prev;

  always_comb begin
    pending_nxt = ~s2;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign any_pend = |pending;
  assign gs_n     = ei_n | ~any_pend;
  assign eo_n     = ei_n | any_pend;

  // GAP lasts one cycle and then decides exactly like IDLE; code is held without preemption.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      code  <= '0;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (!ei_n && any_pend) begin
            code  <= highest_idx(pending);
            valid <= 1'b1;
            state <= PRESENT;
          end else begin
            state <= IDLE;
          end
        end
        PRESENT: begin
          if (ack) begin
            valid <= 1'b0;
            state <= GAP;
          end
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_encoder_148.sv
// Self-checking bench for irq_encoder_148 with a cycle-level behavioural model.
module tb_irq_encoder_148;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_n = 8'hFF;
  logic       ei_n  = 1'b0;
  logic       ack   = 1'b0;
  logic [2:0] code;
  logic       valid;
  logic       gs_n;
  logic       eo_n;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  irq_encoder_148 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req_n (req_n),
    .ei_n  (ei_n),
    .ack   (ack),
    .code  (code),
    .valid (valid),
    .gs_n  (gs_n),
    .eo_n  (eo_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: hN holds req_n as sampled N edges ago; the synchronised level seen by capture is h2.
  logic [7:0] m_pend, h1, h2, h3;
  logic       m_valid;
  logic [2:0] m_code;

  function automatic logic [2:0] top_idx(input logic [7:0] p);
    return 3'($clog2(int'(p) + 1) - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend  <= 8'h00;
      h1      <= 8'hFF;
      h2      <= 8'hFF;
      h3      <= 8'hFF;
      m_valid <= 1'b0;
      m_code  <= 3'd0;
    end else begin
      logic [7:0] np;
      logic       take;
      take = m_valid && ack;
`ifdef IRQ_EDGE_CAPTURE_EN
      np = (m_pend & ~(take ? (8'd1 << m_code) : 8'd0)) | (h3 & ~h2);
`else
      np = ~h2;
`endif
      if (m_valid) begin
        if (take) m_valid <= 1'b0;
      end else if (!ei_n && m_pend != 8'h00) begin
        m_valid <= 1'b1;
        m_code  <= top_idx(m_pend);
      end
      m_pend <= np;
      h3     <= h2;
      h2     <= h1;
      h1     <= req_n;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("valid", 32'(valid), 32'(m_valid));
      check("code", 32'(code), 32'(m_code));
      check("gs_n", 32'(gs_n), 32'(ei_n | (m_pend == 8'h00)));
      check("eo_n", 32'(eo_n), 32'(ei_n | (m_pend != 8'h00)));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    step(2);
    check("rst_code", 32'(code), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_gs_n", 32'(gs_n), 32'd1);
    check("rst_eo_n", 32'(eo_n), 32'd0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    step(2);

    // Single request on bit 5, one-cycle pulse.
    req_n[5] = 1'b0;
    step(1);
    req_n[5] = 1'b1;
    step(2);
    check("a_gs_e3", 32'(gs_n), 32'd0);
    step(1);
    check("a_valid_e4", 32'(valid), 32'd1);
    check("a_code_e4", 32'(code), 32'd5);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("a_gap_valid", 32'(valid), 32'd0);
    step(1);
    check("a_idle_valid", 32'(valid), 32'd0);
    check("a_idle_gs_n", 32'(gs_n), 32'd1);
    check("a_idle_eo_n", 32'(eo_n), 32'd0);

    // Enable held off while bit 3 is requested.
    ei_n     = 1'b1;
    req_n[3] = 1'b0;
    step(4);
    check("b_valid_off", 32'(valid), 32'd0);
    check("b_gs_n_off", 32'(gs_n), 32'd1);
    check("b_eo_n_off", 32'(eo_n), 32'd1);
    ei_n = 1'b0;
    step(1);
    check("b_valid_on", 32'(valid), 32'd1);
    check("b_code_on", 32'(code), 32'd3);
    ack      = 1'b1;
    req_n[3] = 1'b1;
    step(6);
    ack = 1'b0;
    step(2);

`ifdef IRQ_EDGE_CAPTURE_EN
    // Simultaneous requests, no preemption, and capture on the ack edge.
    req_n[2] = 1'b0;
    req_n[6] = 1'b0;
    step(1);
    req_n[2] = 1'b1;
    req_n[6] = 1'b1;
    step(3);
    check("c_code6", 32'(code), 32'd6);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("c_gap", 32'(valid), 32'd0);
    step(1);
    check("c_valid2", 32'(valid), 32'd1);
    check("c_code2", 32'(code), 32'd2);
    req_n[7] = 1'b0;
    step(1);
    req_n[7] = 1'b1;
    step(3);
    check("c_nopreempt", 32'(code), 32'd2);
    req_n[2] = 1'b0;
    step(1);
    req_n[2] = 1'b1;
    step(1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("c_gap2", 32'(valid), 32'd0);
    step(1);
    check("c_code7", 32'(code), 32'd7);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(1);
    check("c_kept2_valid", 32'(valid), 32'd1);
    check("c_kept2_code", 32'(code), 32'd2);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(2);
    check("c_done", 32'(valid), 32'd0);
`else
    // Level mode: a request held through ack is presented again after the gap.
    req_n[4] = 1'b0;
    step(4);
    check("l_valid4", 32'(valid), 32'd1);
    check("l_code4", 32'(code), 32'd4);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("l_gap", 32'(valid), 32'd0);
    step(1);
    check("l_repres_valid", 32'(valid), 32'd1);
    check("l_repres_code", 32'(code), 32'd4);
    req_n[4] = 1'b1;
    ack      = 1'b1;
    step(6);
    ack = 1'b0;
    step(2);
`endif

    // Asynchronous reset in the middle of a presentation.
    req_n[1] = 1'b0;
    step(1);
    req_n[1] = 1'b1;
    step(3);
    check("r_valid_pre", 32'(valid), 32'd1);
    check("r_code_pre", 32'(code), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("r_valid_now", 32'(valid), 32'd0);
    check("r_gs_n_now", 32'(gs_n), 32'd1);
    check("r_code_now", 32'(code), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(3);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      ack  = 1'($urandom_range(0, 1));
      ei_n = ($urandom_range(0, 9) == 0);
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 7) == 0) req_n[b] = ~req_n[b];
      end
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_encoder_148.md
# irq_encoder_148

Clocked 8-to-3 priority encoder with request capture and a valid/ack handshake. It is the encode direction of the 3-to-8 line decoder already in this design, and keeps the 74LS148 enable/cascade pins (EI, EO, GS). Eight asynchronous active-low request lines are synchronised and captured into a pending register. The highest-index pending request is presented as a stable 3-bit code until a consumer acknowledges it. The block sits between external request sources (switches, peripherals) and a controller that dispatches on the code.

## Interface
- N_REQ, 8, number of request lines; fixed at 8 for this revision
- CODE_W, 3, code width, $clog2(N_REQ)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous assert, active-low
- req_n  in  8  request lines, active-low, asynchronous to clk
- ei_n  in  1  enable input, active-low, synchronous to clk
- ack  in  1  consumer acknowledge; used only while valid=1
- code  out  3  index of the presented request, active-high
- valid  out  1  code is presented and stable
- gs_n  out  1  group select, low when enabled and any request is pending
- eo_n  out  1  enable out, low when enabled and nothing is pending (cascade to next stage's ei_n)

## Operation
- Each req_n bit passes through a 2-flop synchroniser (s1, s2), then a previous-value flop s2_prev. All three reset to 1 (inactive).
- Capture: pending[i] sets on an s2 falling transition (s2=0, s2_prev=1). See Configuration for level mode.
- Priority: bit 7 is highest and bit 0 is lowest.
- FSM states: IDLE, PRESENT, GAP.
- IDLE: if ei_n=0 and pending≠0, register code=highest pending index, set valid=1, go to PRESENT. Otherwise stay in IDLE.
- PRESENT: code and valid are held. New requests, including higher-priority ones, do not change code (no preemption).
- PRESENT with ack=1: clear pending[code], set valid=0, go to GAP.
- GAP: valid=0 for exactly one cycle. Then behave as IDLE: go to PRESENT if enabled and pending≠0, else go to IDLE.
- ack while not in PRESENT is ignored.
- Same-edge clear and capture on one bit: the capture wins and the bit stays pending, so the new event is not lost.
- A capture on a bit that is already pending merges with it and produces no second event.
- ei_n=1 blocks any new presentation. Capture continues, and an in-progress PRESENT still completes on ack.
- gs_n = ei_n | ~(|pending); eo_n = ei_n | (|pending). Both are combinational from registered pending and ei_n.
- code is undefined-free: it holds its last value when valid=0.

## Timing
- Reset values: code=0, valid=0, pending=0, state=IDLE, gs_n=1, eo_n=ei_n.
- rst_n low forces these values immediately, including mid-PRESENT; the in-flight request is dropped.
- Request latency, counting the first edge that samples req_n low as edge 1:
  - edge 2: s2=0
  - edge 3: pending set; gs_n falls after this edge
  - edge 4: valid=1
- Ack: sampled on the edge where valid=1 and ack=1. valid is low for the following cycle (GAP). The next code can appear at the edge after that.
- Back-to-back throughput: one code per 2 cycles, given an immediate ack.
- ei_n 1→0 with pending≠0 in IDLE: valid rises at the next edge.

## Configuration
- IRQ_EDGE_CAPTURE_EN defined: edge capture as described. pending is cleared only by ack.
- IRQ_EDGE_CAPTURE_EN undefined (level mode): pending <= ~s2 each cycle and ack does not clear it. Latency is unchanged. A request still held low after ack is presented again after GAP.

## Structure
- Package irq_enc_pkg holds:
  - N_REQ, CODE_W
  - state enum {IDLE, PRESENT, GAP}
  - a function returning the highest set index of an 8-bit vector
- Sub-module req_sync: a parameterised-width 2-flop synchroniser plus s2_prev, with reset value 1. It is instantiated once with width 8.

## Test plan
- Reset with req_n=8'hFF, ei_n=0 → code=0, valid=0, gs_n=1, eo_n=0.
- req_n[5] driven low at edge 1 → gs_n=0 after edge 3; valid=1 and code=5 after edge 4. One-cycle ack → valid=0 for one cycle, then gs_n=1, eo_n=0.
- req_n[2] and req_n[6] fall together → code=6 first; after ack and GAP, code=2; after a second ack, valid stays 0.
- Presenting code=2, then req_n[7] falls → code stays 2 until ack, then 7 follows after GAP. In the edge build, a new edge on bit 2 on the ack edge keeps pending[2]=1.
- ei_n=1 while req_n[3] falls → valid=0, gs_n=1, eo_n=1. Drop ei_n to 0 → valid=1, code=3 on the next edge.
- Level build: hold req_n[4] low through ack → code=4 is re-presented two cycles after ack. rst_n pulsed low mid-PRESENT → valid=0 immediately and pending=0.
